hms_time_counter: RTL and testbench

//  Consumer end of the seconds-clock path: takes the 1 Hz clk_out of sec_clk as a level input.

---
 rtl/clock_pkg.sv | 26 ++
 rtl/sec_edge_sync.sv | 41 ++++
 rtl/hms_time_counter.sv | 157 +++++++++++++++
 tb/tb_hms_time_counter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Purpose: shared constants, time payload struct and FSM state type for the
// seconds-clock path (sec_clk, hms_time_counter, display stage).
// Contents:
//   SEC_MAX, MIN_MAX : last seconds / minutes values before carry
//   HH_W, MS_W       : hour and minute/second field widths
//   hms_t            : packed hh:mm:ss time payload
//   state_e          : load handshake FSM state {RUN, LOAD}
package clock_pkg;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HH_W    = 5;
  localparam int unsigned MS_W    = 6;

  typedef struct packed {
    logic [HH_W-1:0] hh;
    logic [MS_W-1:0] mm;
    logic [MS_W-1:0] ss;
  } hms_t;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_e;

endpackage

// File: rtl/sec_edge_sync.sv
// Purpose: bring the 1 Hz seconds square wave into the clk_in domain and
// flag each rising edge as a single-cycle tick.
// Parameters:
//   SYNC_STAGES : synchroniser depth, legal values 2..3
// Ports:
//   clk_in     in  system clock, rising edge
//   rst        in  synchronous active-low reset
//   sec_clk_in in  asynchronous 1 Hz level
//   tick       out one-cycle strobe on each synchronised rising edge
module sec_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sec_clk_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   dly_q;

  // Shift the raw level in at bit 0; the top bit is the synchronised level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sec_clk_in};
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  // Rising edge only: high level and falling edge produce nothing.
  assign tick = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/hms_time_counter.sv
// Purpose: hh:mm:ss time-of-day counter advanced by the synchronised 1 Hz
// seconds edge, with a validated load handshake for setting the time.
// Optional feature: define CLOCK_ALARM_EN to add the alarm compare.
// Parameters:
//   SYNC_STAGES : seconds-input synchroniser depth (2..3)
//   HOUR_MAX    : last hour before the day wraps (23 -> 24 h, 11 -> 0..11)
// Ports:
//   clk_in, rst            : 65536 Hz clock, synchronous active-low reset
//   sec_clk_in             : asynchronous 1 Hz square wave
//   run                    : 1 = count, 0 = hold (ticks dropped)
//   set_valid/set_hh/mm/ss : load request and time to load
//   set_ready, set_err     : handshake ready, one-cycle range-error pulse
//   hh, mm, ss             : current time, binary
//   sec_pulse, day_wrap    : one-cycle increment / end-of-day pulses
//   alarm_arm/hh/mm, alarm_fire : alarm compare (CLOCK_ALARM_EN only)
module hms_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOUR_MAX    = 23
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            sec_clk_in,
  input  logic            run,
  input  logic            set_valid,
  input  logic [HH_W-1:0] set_hh,
  input  logic [MS_W-1:0] set_mm,
  input  logic [MS_W-1:0] set_ss,
`ifdef CLOCK_ALARM_EN
  input  logic            alarm_arm,
  input  logic [HH_W-1:0] alarm_hh,
  input  logic [MS_W-1:0] alarm_mm,
  output logic            alarm_fire,
`endif
  output logic            set_ready,
  output logic            set_err,
  output logic [HH_W-1:0] hh,
  output logic [MS_W-1:0] mm,
  output logic [MS_W-1:0] ss,
  output logic            sec_pulse,
  output logic            day_wrap
);

  logic   tick;
  logic   load_acc;
  logic   load_ok;
  logic   inc;

  state_e state_q, state_d;
  hms_t   now_q, now_d;
  logic   set_ready_q, set_ready_d;
  logic   set_err_q, set_err_d;
  logic   sec_pulse_q, sec_pulse_d;
  logic   day_wrap_q, day_wrap_d;
`ifdef CLOCK_ALARM_EN
  logic   alarm_fire_q, alarm_fire_d;
`endif

  sec_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sec_edge_sync (
    .clk_in    (clk_in),
    .rst       (rst),
    .sec_clk_in(sec_clk_in),
    .tick      (tick)
  );

  // Handshake FSM, load check and time increment.
  always_comb begin
    state_d     = state_q;
    now_d       = now_q;
    set_err_d   = 1'b0;
    sec_pulse_d = 1'b0;
    day_wrap_d  = 1'b0;
`ifdef CLOCK_ALARM_EN
    alarm_fire_d = 1'b0;
`endif

    load_acc = set_valid & set_ready_q;
    load_ok  = (set_hh <= HH_W'(HOUR_MAX)) && (set_mm <= MS_W'(MIN_MAX)) &&
               (set_ss <= MS_W'(SEC_MAX));
    // An accepted load swallows a coincident tick.
    inc      = tick & run & ~load_acc;

    unique case (state_q)
      RUN:  if (load_acc) state_d = LOAD;
      LOAD: state_d = RUN;
    endcase
    set_ready_d = (state_d == RUN);

    if (load_acc) begin
      if (load_ok) now_d = '{hh: set_hh, mm: set_mm, ss: set_ss};
      else         set_err_d = 1'b1;
    end else if (inc) begin
      sec_pulse_d = 1'b1;
      if (now_q.ss == MS_W'(SEC_MAX)) begin
        now_d.ss = '0;
        if (now_q.mm == MS_W'(MIN_MAX)) begin
          now_d.mm = '0;
          if (now_q.hh == HH_W'(HOUR_MAX)) begin
            now_d.hh   = '0;
            day_wrap_d = 1'b1;
          end else begin
            now_d.hh = now_q.hh + HH_W'(1);
          end
        end else begin
          now_d.mm = now_q.mm + MS_W'(1);
        end
      end else begin
        now_d.ss = now_q.ss + MS_W'(1);
      end
    end

`ifdef CLOCK_ALARM_EN
    // Only an increment can fire; loading onto the alarm time is silent.
    alarm_fire_d = inc & alarm_arm & (now_d.hh == alarm_hh) &
                   (now_d.mm == alarm_mm) & (now_d.ss == '0);
`endif
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q     <= RUN;
      now_q       <= '0;
      set_ready_q <= 1'b0;
      set_err_q   <= 1'b0;
      sec_pulse_q <= 1'b0;
      day_wrap_q  <= 1'b0;
`ifdef CLOCK_ALARM_EN
      alarm_fire_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      now_q       <= now_d;
      set_ready_q <= set_ready_d;
      set_err_q   <= set_err_d;
      sec_pulse_q <= sec_pulse_d;
      day_wrap_q  <= day_wrap_d;
`ifdef CLOCK_ALARM_EN
      alarm_fire_q <= alarm_fire_d;
`endif
    end
  end

  assign set_ready = set_ready_q;
  assign set_err   = set_err_q;
  assign hh        = now_q.hh;
  assign mm        = now_q.mm;
  assign ss        = now_q.ss;
  assign sec_pulse = sec_pulse_q;
  assign day_wrap  = day_wrap_q;
`ifdef CLOCK_ALARM_EN
  assign alarm_fire = alarm_fire_q;
`endif

endmodule

// File: tb/tb_hms_time_counter.sv
// Directed plus randomized bench for hms_time_counter. The reference keeps the
// time as seconds-of-day and applies the counting, load and handshake rules
// with plain arithmetic. Define CLOCK_ALARM_EN to include the alarm checks.
module tb_hms_time_counter;

  localparam int unsigned HOUR_MAX = 23;
  localparam int          DAY_S    = (HOUR_MAX + 1) * 3600;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       sec_clk_in = 1'b0;
  logic       run = 1'b0;
  logic       set_valid = 1'b0;
  logic [4:0] set_hh = '0;
  logic [5:0] set_mm = '0;
  logic [5:0] set_ss = '0;
  logic       set_ready, set_err, sec_pulse, day_wrap;
  logic [4:0] hh;
  logic [5:0] mm, ss;
`ifdef CLOCK_ALARM_EN
  logic       alarm_arm = 1'b0;
  logic [4:0] alarm_hh = '0;
  logic [5:0] alarm_mm = '0;
  logic       alarm_fire;
  int         fire_cnt = 0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int wrap_cnt = 0;
  int err_cnt = 0;

  // Reference state: seconds of day, handshake readiness, last pulses.
  int m_t = 0;
  bit m_ready = 1'b0;
  bit m_err, m_pulse, m_wrap, m_fire, m_acc;
  // Input levels as seen by the synchroniser chain, oldest first.
  bit lvl[$] = '{1'b0, 1'b0, 1'b0};

  hms_time_counter #(.SYNC_STAGES(2), .HOUR_MAX(HOUR_MAX)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .sec_clk_in(sec_clk_in),
    .run       (run),
    .set_valid (set_valid),
    .set_hh    (set_hh),
    .set_mm    (set_mm),
    .set_ss    (set_ss),
`ifdef CLOCK_ALARM_EN
    .alarm_arm (alarm_arm),
    .alarm_hh  (alarm_hh),
    .alarm_mm  (alarm_mm),
    .alarm_fire(alarm_fire),
`endif
    .set_ready (set_ready),
    .set_err   (set_err),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .sec_pulse (sec_pulse),
    .day_wrap  (day_wrap)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int tod(input int h, input int m, input int s);
    return h * 3600 + m * 60 + s;
  endfunction

  // One clock: advance the reference with the inputs present at the edge,
  // then compare every output 1 time unit later.
  task automatic step();
    bit tick;
    @(posedge clk_in);
    // A level first sampled at edge k counts as a rise at edge k+2.
    tick    = lvl[1] && !lvl[0];
    m_err   = 1'b0;
    m_pulse = 1'b0;
    m_wrap  = 1'b0;
    m_fire  = 1'b0;
    m_acc   = 1'b0;
    if (!rst) begin
      m_t     = 0;
      m_ready = 1'b0;
      lvl     = '{1'b0, 1'b0, 1'b0};
    end else begin
      m_acc = set_valid && m_ready;
      if (m_acc) begin
        if (int'(set_hh) <= HOUR_MAX && set_mm <= 59 && set_ss <= 59)
          m_t = tod(int'(set_hh), int'(set_mm), int'(set_ss));
        else
          m_err = 1'b1;
      end else if (tick && run) begin
        m_t     = (m_t + 1) % DAY_S;
        m_pulse = 1'b1;
        m_wrap  = (m_t == 0);
`ifdef CLOCK_ALARM_EN
        m_fire = alarm_arm && (m_t / 3600 == int'(alarm_hh)) &&
                 ((m_t / 60) % 60 == int'(alarm_mm)) && (m_t % 60 == 0);
`endif
      end
      m_ready = !m_acc;
      lvl.push_back(sec_clk_in);
      void'(lvl.pop_front());
    end
    #1;
    chk("hh", 32'(hh), 32'(m_t / 3600));
    chk("mm", 32'(mm), 32'((m_t / 60) % 60));
    chk("ss", 32'(ss), 32'(m_t % 60));
    chk("set_ready", 32'(set_ready), 32'(m_ready));
    chk("set_err", 32'(set_err), 32'(m_err));
    chk("sec_pulse", 32'(sec_pulse), 32'(m_pulse));
    chk("day_wrap", 32'(day_wrap), 32'(m_wrap));
    if (day_wrap === 1'b1) wrap_cnt++;
    if (set_err === 1'b1) err_cnt++;
`ifdef CLOCK_ALARM_EN
    chk("alarm_fire", 32'(alarm_fire), 32'(m_fire));
    if (alarm_fire === 1'b1) fire_cnt++;
`endif
  endtask

  // Hold set_valid until accepted, bounded.
  task automatic do_load(input int h, input int m, input int s);
    bit done = 1'b0;
    set_hh    = 5'(h);
    set_mm    = 6'(m);
    set_ss    = 6'(s);
    set_valid = 1'b1;
    for (int i = 0; i < 8 && !done; i++) begin
      step();
      done = m_acc;
    end
    set_valid = 1'b0;
    if (!done) chk("load_accept_timeout", 32'(0), 32'(1));
  endtask

  // n full seconds-clock periods, slow relative to the synchroniser.
  task automatic sec_edges(input int n);
    for (int i = 0; i < n; i++) begin
      sec_clk_in = 1'b1;
      repeat (4) step();
      sec_clk_in = 1'b0;
      repeat (4) step();
    end
  endtask

  initial begin
    // 1: reset with the seconds input toggling, then first counted second.
    run = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sec_clk_in = (i % 2 == 0);
      step();
    end
    sec_clk_in = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("t1_ready_after_reset", 32'(set_ready), 32'(1));
    sec_clk_in = 1'b1;
    repeat (2) step();
    chk("t1_ss_before", 32'(ss), 32'(0));
    step();
    chk("t1_ss_first", 32'(ss), 32'(1));
    sec_clk_in = 1'b0;
    repeat (3) step();

    // 2: end-of-day wrap.
    do_load(23, 59, 58);
    step();
    wrap_cnt = 0;
    sec_edges(1);
    chk("t2_2359_59", 32'(tod(int'(hh), int'(mm), int'(ss))), 32'(tod(23, 59, 59)));
    sec_edges(1);
    chk("t2_midnight", 32'(tod(int'(hh), int'(mm), int'(ss))), 32'(0));
    chk("t2_wrap_once", 32'(wrap_cnt), 32'(1));

    // 3: out-of-range hour is rejected.
    do_load(3, 4, 5);
    step();
    err_cnt = 0;
    do_load(24, 0, 0);
    chk("t3_ready_low", 32'(set_ready), 32'(0));
    step();
    chk("t3_ready_back", 32'(set_ready), 32'(1));
    chk("t3_time_kept", 32'(tod(int'(hh), int'(mm), int'(ss))), 32'(tod(3, 4, 5)));
    chk("t3_err_once", 32'(err_cnt), 32'(1));

    // 4: load coincides with a tick; load wins.
    sec_clk_in = 1'b1;
    repeat (2) step();
    set_hh = 5'd10; set_mm = 6'd20; set_ss = 6'd30;
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    chk("t4_accepted", 32'(m_acc), 32'(1));
    chk("t4_time", 32'(tod(int'(hh), int'(mm), int'(ss))), 32'(tod(10, 20, 30)));
    chk("t4_no_pulse", 32'(sec_pulse), 32'(0));
    repeat (2) step();
    sec_clk_in = 1'b0;
    repeat (4) step();

    // 5: run low freezes time; reset during LOAD clears it.
    run = 1'b0;
    sec_edges(3);
    chk("t5_frozen", 32'(tod(int'(hh), int'(mm), int'(ss))), 32'(tod(10, 20, 30)));
    run = 1'b1;
    sec_edges(1);
    chk("t5_resume", 32'(tod(int'(hh), int'(mm), int'(ss))), 32'(tod(10, 20, 31)));
    do_load(5, 5, 5);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t5_reset_in_load", 32'(tod(int'(hh), int'(mm), int'(ss))), 32'(0));
    repeat (2) step();

`ifdef CLOCK_ALARM_EN
    // 6: alarm fires on increment, not on load.
    alarm_arm = 1'b1; alarm_hh = 5'd7; alarm_mm = 6'd30;
    do_load(7, 29, 59);
    step();
    fire_cnt = 0;
    sec_edges(1);
    chk("t6_fire_once", 32'(fire_cnt), 32'(1));
    fire_cnt = 0;
    do_load(7, 30, 0);
    repeat (3) step();
    chk("t6_load_no_fire", 32'(fire_cnt), 32'(0));
`endif

    // Randomized traffic: fast toggles, run gaps, loads near boundaries, resets.
`ifdef CLOCK_ALARM_EN
    alarm_arm = 1'b1; alarm_hh = 5'd23; alarm_mm = 6'd59;
`endif
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) sec_clk_in = ~sec_clk_in;
      run = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 199) != 0);
      if (!set_valid && $urandom_range(0, 11) == 0) begin
        set_hh = ($urandom_range(0, 1) == 1) ? 5'(HOUR_MAX) : 5'($urandom_range(0, 25));
        set_mm = ($urandom_range(0, 1) == 1) ? 6'd59 : 6'($urandom_range(0, 61));
        set_ss = 6'($urandom_range(55, 61));
        set_valid = 1'b1;
      end
      step();
      if (m_acc) set_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
